mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL use one clock, clk; reset is rst, asynchronous and active-high.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  pipeline clock
- rst  in  1  async active-high reset
- i_addr  in  16  fetch word address (the pc)
- i_re  in  1  fetch request
- instr  out  16  fetched instruction, valid when freeze=0
- d_addr  in  16  data word address (EX/MEM ALU result)
- d_re  in  1  load request
- d_we  in  1  store request
- d_wdata  in  16  store data
- rd_data  out  16  load data, valid when freeze=0
- freeze  out  1  stall all pipeline registers
- m_req  out  1  backing-memory request
- m_we  out  1  backing-memory write
- m_addr  out  16  backing-memory address
- m_wdata  out  16  backing-memory write data
- m_rdata  in  16  backing-memory read data
- m_ack  in  1  one-cycle completion pulse
- stall_cnt  out  16  frozen-cycle counter

Function
REQ-003 SHALL serve both fetch and data traffic through one single-ported, variable-latency backing memory.
REQ-004 SHALL hold a one-entry fetch buffer (ibuf_valid, ibuf_addr, ibuf_data); ihit = i_re & ibuf_valid & (ibuf_addr==i_addr).
REQ-005 SHALL drive instr = ibuf_data combinationally on ihit, else 16'h0000.
REQ-006 SHALL compute freeze = (i_re & ~ihit) | ((d_re|d_we) & ~d_done), combinationally.
REQ-007 SHALL implement FSM states IDLE, DREQ and IREQ.
REQ-008 SHALL transition from IDLE to DREQ when (d_re|d_we) & ~d_done, else to IREQ when i_re & ~ihit, else stay in IDLE; the data side has priority.
REQ-009 SHALL, in DREQ, assert m_req=1, m_we=d_we, m_addr=d_addr, m_wdata=d_wdata, all registered and held stable until m_ack.
REQ-010 SHALL, in IREQ, assert m_req=1, m_we=0, m_addr=i_addr, all registered and held until m_ack.
REQ-011 SHALL, on m_ack in DREQ, capture m_rdata into rd_data (loads only), set d_done, and return to IDLE.
REQ-012 SHALL, on m_ack in IREQ, load ibuf with {1, m_addr, m_rdata} and return to IDLE.
REQ-013 SHALL hold d_done until the first cycle with freeze=0, and clear it at that clock edge.
- d_done therefore survives a concurrent fetch miss.
REQ-014 SHALL hold rd_data stable until the next load completes.
REQ-015 SHALL clear ibuf_valid when a store completes (m_ack in DREQ with m_we=1) with m_addr==ibuf_addr.
- Clearing has priority over any same-cycle hit.
REQ-016 SHALL ignore m_ack while in IDLE.
REQ-017 SHALL give the following latency:
- fetch hit: 0 cycles (freeze=0);
- fetch miss: 1 cycle to enter IREQ, plus N cycles of m_req until m_ack, plus 1 hit cycle;
- data access: 1 + N cycles frozen, then released.
REQ-018 SHALL treat d_re & d_we both high as a store.
REQ-019 SHALL increment stall_cnt on every clock with freeze=1, saturating at 16'hFFFF.

Reset
REQ-020 SHALL, while rst=1, force the following immediately (asynchronously), including mid-transaction:
- state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0;
- ibuf_valid=0, ibuf_addr=0, ibuf_data=0;
- d_done=0, rd_data=0, stall_cnt=0.
REQ-021 SHALL drop any in-flight transaction without waiting for m_ack; an m_ack in the first cycle after reset is ignored per REQ-016.

Structure
REQ-022 SHALL place the FSM state enum (IDLE/DREQ/IREQ), ADDR_W=16 and DATA_W=16 in the shared package mem_ctrl_pkg.
REQ-023 SHALL implement the fetch buffer as the sub-module ifetch_buf (hit compare, fill, invalidate).

Verification
REQ-024 SHALL cover these directed scenarios:
- Cold fetch i_addr=0x0010, memory returns 0x1234 with m_ack 3 cycles after m_req -> freeze=1 for 4 cycles, then instr=0x1234, freeze=0.
- Refetch 0x0010 -> freeze=0 the same cycle, m_req stays 0.
- Simultaneous fetch miss 0x0011 and load d_addr=0x0100 (mem=0xBEEF) -> DREQ issued first, then IREQ; rd_data=0xBEEF held with d_done=1 until freeze falls.
- Store d_addr=0x0010, d_wdata=0x5555, then fetch 0x0010 -> ibuf invalidated, new IREQ issued, instr=0x5555.
- rst pulsed while in DREQ with m_req=1 -> m_req=0 immediately; stall_cnt=0; a stray m_ack next cycle causes no state change.
- Hold freeze=1 for 70000 cycles -> stall_cnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the unified fetch/data memory port controller.
package mem_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// One-entry instruction buffer: hit compare, fill from memory, invalidate on
// a matching store.
module ifetch_buf
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_inval,
    input  logic [ADDR_W-1:0] i_inval_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // A store that overwrites the buffered word kills the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_inval && (i_inval_addr == r_addr)) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_addr  <= i_fill_addr;
            r_data  <= i_fill_data;
        end
    end

    assign o_hit  = i_re & r_valid & (r_addr == i_addr);
    assign o_data = o_hit ? r_data : '0;

endmodule

// File: rtl/mem_port_ctrl.sv
// Arbitrates pipeline fetch and load/store traffic onto one single-ported,
// variable-latency backing memory, freezing the pipeline while it waits.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_re,
    output logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              freeze,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [DATA_W-1:0] stall_cnt
);

    state_t            r_state;
    state_t            w_next;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_d_done;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_stall_cnt;
    logic              w_ihit;
    logic              w_dpend;
    logic              w_imiss;
    logic              w_freeze;
    logic              w_fill;
    logic              w_inval;

    assign w_dpend  = (d_re | d_we) & ~r_d_done;
    assign w_imiss  = i_re & ~w_ihit;
    assign w_freeze = w_imiss | w_dpend;
    assign w_fill   = (r_state == IREQ) & m_ack;
    assign w_inval  = (r_state == DREQ) & m_ack & r_m_we;

    ifetch_buf u_ibuf (
        .clk          (clk),
        .rst          (rst),
        .i_re         (i_re),
        .i_addr       (i_addr),
        .i_fill       (w_fill),
        .i_fill_addr  (r_m_addr),
        .i_fill_data  (m_rdata),
        .i_inval      (w_inval),
        .i_inval_addr (r_m_addr),
        .o_hit        (w_ihit),
        .o_data       (instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Data side wins arbitration so a load/store is never starved by fetches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_dpend) begin
                    w_next = DREQ;
                end else if (w_imiss) begin
                    w_next = IREQ;
                end
            end
            DREQ, IREQ: begin
                if (m_ack) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (r_state == IDLE) begin
            if (w_dpend) begin
                r_m_req   <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
            end else if (w_imiss) begin
                r_m_req  <= 1'b1;
                r_m_we   <= 1'b0;
                r_m_addr <= i_addr;
            end
        end else if (m_ack) begin
            r_m_req <= 1'b0;
        end
    end

    // d_done must outlive a following fetch miss, so it only clears on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_done    <= 1'b0;
            r_rd_data   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state == DREQ) && m_ack) begin
                r_d_done <= 1'b1;
                if (!r_m_we) begin
                    r_rd_data <= m_rdata;
                end
            end else if (!w_freeze) begin
                r_d_done <= 1'b0;
            end
            if (w_freeze) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign freeze    = w_freeze;
    assign m_req     = r_m_req;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign rd_data   = r_rd_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a fixed-latency backing-memory responder.
module tb_mem_port_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] i_addr;
    logic        i_re;
    logic [15:0] instr;
    logic [15:0] d_addr;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_wdata;
    logic [15:0] rd_data;
    logic        freeze;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ack;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    logic        respOn;
    int          strayReq;
    logic        prevReq;
    int          reqCount;
    logic [15:0] reqAddr  [4];
    logic        reqWe    [4];
    logic [15:0] reqWdata [4];
    int          nFrozen;

    localparam int RESP_LATENCY = 3;

    mem_port_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_re      (i_re),
        .instr     (instr),
        .d_addr    (d_addr),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_wdata   (d_wdata),
        .rd_data   (rd_data),
        .freeze    (freeze),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: acks on the RESP_LATENCY-th cycle of m_req, at the falling edge.
    initial begin
        logic [15:0] memArr [0:1023];
        int cnt;
        int strayDone;
        for (int i = 0; i < 1024; i++) memArr[i] = 16'h0000;
        memArr[16'h0010] = 16'h1234;
        memArr[16'h0011] = 16'hA0A0;
        memArr[16'h0100] = 16'hBEEF;
        cnt = 0;
        strayDone = 0;
        m_ack = 1'b0;
        m_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (strayReq != strayDone) begin
                strayDone = strayReq;
                m_ack = 1'b1;
                m_rdata = 16'hDEAD;
            end else if (m_req && respOn) begin
                cnt++;
                if (cnt == RESP_LATENCY) begin
                    m_ack = 1'b1;
                    m_rdata = m_we ? 16'h0000 : memArr[m_addr[9:0]];
                    if (m_we) memArr[m_addr[9:0]] = m_wdata;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ire, input logic [15:0] ia, input logic dre,
                                 input logic dwe, input logic [15:0] da, input logic [15:0] dw);
        i_re    = ire;
        i_addr  = ia;
        d_re    = dre;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dw;
        #1;
    endtask

    // Counts frozen cycles until release and logs each new memory request.
    task automatic waitRelease(input int maxCyc);
        nFrozen  = 0;
        reqCount = 0;
        prevReq  = m_req;
        while (freeze && (nFrozen < maxCyc)) begin
            nFrozen++;
            @(posedge clk);
            #1;
            if (m_req && !prevReq && (reqCount < 4)) begin
                reqAddr[reqCount]  = m_addr;
                reqWe[reqCount]    = m_we;
                reqWdata[reqCount] = m_wdata;
                reqCount++;
            end
            prevReq = m_req;
        end
        checkOutput("released", {15'd0, freeze}, 16'h0000);
    endtask

    initial begin
        respOn   = 1'b1;
        strayReq = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_freeze", {15'd0, freeze}, 16'h0000);
        checkOutput("rst_mreq", {15'd0, m_req}, 16'h0000);
        checkOutput("rst_stall", stall_cnt, 16'h0000);
        checkOutput("rst_rddata", rd_data, 16'h0000);

        $display("[TB] cold fetch 0x0010");
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        waitRelease(20);
        checkOutput("cold_frozen", 16'(nFrozen), 16'd4);
        checkOutput("cold_nreq", 16'(reqCount), 16'd1);
        checkOutput("cold_maddr", reqAddr[0], 16'h0010);
        checkOutput("cold_instr", instr, 16'h1234);
        checkOutput("cold_stall", stall_cnt, 16'd4);

        $display("[TB] refetch 0x0010");
        @(posedge clk);
        #1;
        checkOutput("hit_freeze", {15'd0, freeze}, 16'h0000);
        checkOutput("hit_mreq", {15'd0, m_req}, 16'h0000);
        checkOutput("hit_instr", instr, 16'h1234);
        checkOutput("hit_stall", stall_cnt, 16'd4);

        $display("[TB] fetch miss 0x0011 with load 0x0100");
        applyStimulus(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0100, 16'h0000);
        waitRelease(30);
        checkOutput("mix_frozen", 16'(nFrozen), 16'd8);
        checkOutput("mix_nreq", 16'(reqCount), 16'd2);
        checkOutput("mix_first_addr", reqAddr[0], 16'h0100);
        checkOutput("mix_first_we", {15'd0, reqWe[0]}, 16'h0000);
        checkOutput("mix_second_addr", reqAddr[1], 16'h0011);
        checkOutput("mix_second_we", {15'd0, reqWe[1]}, 16'h0000);
        checkOutput("mix_rddata", rd_data, 16'hBEEF);
        checkOutput("mix_instr", instr, 16'hA0A0);
        applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("mix_rd_held", rd_data, 16'hBEEF);
        checkOutput("mix_after_freeze", {15'd0, freeze}, 16'h0000);
        checkOutput("mix_stall", stall_cnt, 16'd12);

        $display("[TB] refill 0x0010, then store over it");
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        waitRelease(20);
        checkOutput("refill_frozen", 16'(nFrozen), 16'd4);
        checkOutput("refill_instr", instr, 16'h1234);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'h5555);
        waitRelease(30);
        checkOutput("st_frozen", 16'(nFrozen), 16'd8);
        checkOutput("st_nreq", 16'(reqCount), 16'd2);
        checkOutput("st_first_we", {15'd0, reqWe[0]}, 16'h0001);
        checkOutput("st_first_addr", reqAddr[0], 16'h0010);
        checkOutput("st_first_wdata", reqWdata[0], 16'h5555);
        checkOutput("st_refetch_we", {15'd0, reqWe[1]}, 16'h0000);
        checkOutput("st_refetch_addr", reqAddr[1], 16'h0010);
        checkOutput("st_instr", instr, 16'h5555);
        checkOutput("st_rd_untouched", rd_data, 16'hBEEF);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("st_stall", stall_cnt, 16'd24);

        $display("[TB] reset during DREQ");
        respOn = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("dreq_mreq", {15'd0, m_req}, 16'h0001);
        checkOutput("dreq_maddr", m_addr, 16'h0200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_mreq", {15'd0, m_req}, 16'h0000);
        checkOutput("arst_maddr", m_addr, 16'h0000);
        checkOutput("arst_stall", stall_cnt, 16'h0000);
        checkOutput("arst_rddata", rd_data, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        strayReq = strayReq + 1;
        @(posedge clk);
        #1;
        checkOutput("stray_mreq", {15'd0, m_req}, 16'h0000);
        checkOutput("stray_freeze", {15'd0, freeze}, 16'h0000);
        checkOutput("stray_rddata", rd_data, 16'h0000);
        checkOutput("stray_stall", stall_cnt, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("stray_idle_mreq", {15'd0, m_req}, 16'h0000);

        $display("[TB] long freeze for saturation");
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("sat_stall", stall_cnt, 16'hFFFF);
        checkOutput("sat_freeze", {15'd0, freeze}, 16'h0001);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("sat_stall_held", stall_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
